cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache of the pipelined core.
- Accepts line-sized read requests from the I-cache and read/write requests from the D-cache.
- Grants one requester at a time and captures its address and write data into internal registers.
- Holds the memory request stable until the memory responds, then routes the response back to the granted cache only.

Parameters:
ADDR_W, 16, width of byte address on all ports
LINE_W, 128, width of one cache line (data buses)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  read line to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write-back request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back line
d_rdata  out  LINE_W  read line to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_address  out  ADDR_W  physical memory address
pmem_wdata  out  LINE_W  physical memory write line
pmem_rdata  in  LINE_W  physical memory read line
pmem_resp  in  1  physical memory completion pulse

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- Reset (reset==0, asynchronous, valid at any time including mid-transaction): state=IDLE; pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0; captured-op registers cleared.
- An in-flight memory transaction is abandoned on reset; no response is forwarded.

IDLE:
- If any request is pending, grant per the priority rule below.
- On grant, capture addr (plus wdata/op for D) into registers and move to SERVE_x on the next edge.
- No requests: stay in IDLE.

Priority (macro off):
- D-cache wins when d_read|d_write and i_read are sampled together.
- D-cache is fixed-priority; the I-cache can starve while the D-cache requests back-to-back (accepted).

SERVE_x:
- pmem_read/pmem_write, pmem_address and pmem_wdata are driven from the captured registers only.
- Requester-side address/data changes during service are ignored.
- On pmem_resp==1: the granted x_resp=1 combinationally in the same cycle; next state IDLE.

Latency:
- Request seen in IDLE at cycle 0; pmem strobe asserted from cycle 1.
- x_resp coincides with pmem_resp.
- At least one IDLE cycle between consecutive transactions; pmem strobes are 0 in that cycle.

Data and response routing:
- i_rdata = d_rdata = pmem_rdata (shared wire). It is valid only when the matching x_resp is high.
- A non-granted x_resp never asserts.

Requester protocol:
- Each requester must deassert its request in the cycle after its resp. A request still high in IDLE is treated as a new transaction.
- d_read and d_write both high is illegal; the arbiter services it as a write.
- A request dropped mid-service does not abort the transaction. Memory is completed and x_resp is still pulsed.

Misc:
- pmem_resp arriving in IDLE is ignored.
- Only one of pmem_read/pmem_write is ever high.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - Add a last_grant register (reset value = I).
  - On a simultaneous request in IDLE, grant the requester not in last_grant.
  - last_grant updates on every grant.
  - Single requests are granted as usual.
  - Net effect: first tie after reset goes to D, ties then alternate.
- Undefined: fixed D-priority as above; no last_grant register is present.

Test Plan:
1. i_read=1, i_addr=0x1230; pmem_resp after 3 strobe cycles, pmem_rdata=0xA5..A5 -> pmem_read high cycles 1-3, pmem_address=0x1230, i_resp pulses with i_rdata=0xA5..A5, d_resp stays 0, cycle 4 IDLE with strobes 0.
2. Same cycle i_read (0x0040) and d_write (0x0080, wdata=0xDEAD..BEEF) -> pmem_write first with 0x0080/wdata and d_resp; then IDLE gap; then pmem_read 0x0040 and i_resp.
3. Both requesters re-request immediately after every resp, 4 transactions. Macro off -> order D,D,D,D (I starved). Macro on -> order D,I,D,I.
4. During SERVE_D, change d_addr from 0x0100 to 0x0200 and d_wdata -> pmem_address stays 0x0100 and pmem_wdata stays the captured value until d_resp.
5. Assert reset=0 mid SERVE_I, between clock edges -> pmem_read drops immediately and no i_resp. After release, a new i_read to 0x0300 completes normally.
6. d_read and d_write both high at 0x0400 -> pmem_write asserted, pmem_read never asserted, d_resp pulses once.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and the D-cache.
// Optional ARB_ROUND_ROBIN_EN: alternates grants on simultaneous requests (default: fixed D priority).
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              d_req;
  logic              pick_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d_q: 1 when the D-cache held the most recent grant; resets to I
  logic last_d_q, last_d_d;

  always_comb begin
    if (d_req && i_read) pick_d = ~last_d_q;
    else                 pick_d = d_req;
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (d_req || i_read)) last_d_d = pick_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_d_q <= 1'b0;
    else        last_d_q <= last_d_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          // read+write together is serviced as a write
          write_d = d_write;
        end else if (i_read) begin
          state_d = SERVE_I;
          addr_d  = i_addr;
          write_d = 1'b0;
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scoreboard bench for cache_mem_arbiter; expectations follow ARB_ROUND_ROBIN_EN if defined.
module tb_cache_mem_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read, d_read, d_write, pmem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;

  typedef struct packed {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   last_d = 1'b0;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Tie-break as the arbiter policy defines it; records the grant.
  function automatic bit tie_goes_d();
    bit g;
`ifdef ARB_ROUND_ROBIN_EN
    g = ~last_d;
`else
    g = 1'b1;
`endif
    last_d = g;
    return g;
  endfunction

  // Called at the negedge where the strobe must first be visible; holds for
  // 'hold' strobe cycles, responds in the last, then checks the IDLE gap.
  task automatic complete(input logic [LINE_W-1:0] rdata, input int hold);
    txn_t e;
    chk("sb_nonempty", LINE_W'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    for (int k = 0; k < hold; k++) begin
      if (k > 0) @(negedge clk);
      chk("pmem_read", pmem_read, !e.wr);
      chk("pmem_write", pmem_write, e.wr);
      chk("pmem_address", pmem_address, e.addr);
      if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
      chk("early_resp", i_resp | d_resp, 0);
    end
    pmem_rdata = rdata;
    pmem_resp  = 1'b1;
    #1;
    chk("i_resp", i_resp, !e.is_d);
    chk("d_resp", d_resp, e.is_d);
    chk("rdata", e.is_d ? d_rdata : i_rdata, rdata);
    @(negedge clk);
    chk("gap_read", pmem_read, 0);
    chk("gap_write", pmem_write, 0);
    chk("gap_resp", i_resp | d_resp, 0);
    pmem_resp = 1'b0;
  endtask

  initial begin
    reset = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    #2;
    chk("rst_read", pmem_read, 0);
    chk("rst_write", pmem_write, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_resp", i_resp | d_resp, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // 1: single I-cache read, three strobe cycles
    @(negedge clk);
    i_read = 1'b1; i_addr = 16'h1230;
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h1230, wdata: '0}); last_d = 1'b0;
    @(negedge clk);
    complete({16{8'hA5}}, 3);
    i_read = 1'b0;
    @(negedge clk);
    chk("t1_idle", pmem_read | pmem_write, 0);

    // 2: simultaneous I read and D write
    i_read = 1'b1; i_addr = 16'h0040;
    d_write = 1'b1; d_addr = 16'h0080; d_wdata = {4{32'hDEADBEEF}};
    if (tie_goes_d()) begin
      exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h0080, wdata: {4{32'hDEADBEEF}}});
      exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h0040, wdata: '0});
    end else begin
      exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h0040, wdata: '0});
      exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h0080, wdata: {4{32'hDEADBEEF}}});
    end
    @(negedge clk);
    complete({4{32'h11112222}}, 2);
    if (exp_q.size() != 0 && exp_q[0].is_d) i_read = 1'b0; else d_write = 1'b0;
    last_d = exp_q.size() != 0 ? exp_q[0].is_d : last_d;
    @(negedge clk);
    complete({4{32'h33334444}}, 1);
    i_read = 1'b0; d_write = 1'b0;

    // 3: both requesters re-request back to back
    @(negedge clk);
    d_read = 1'b1; d_addr = 16'h0500; i_read = 1'b1; i_addr = 16'h0600;
    for (int n = 0; n < 4; n++) begin
      if (tie_goes_d()) exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 16'h0500, wdata: '0});
      else              exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h0600, wdata: '0});
      @(negedge clk);
      complete({4{32'(32'hC0DE0000 + n)}}, 2);
    end
    d_read = 1'b0; i_read = 1'b0;

    // 4: requester-side changes during service are ignored
    @(negedge clk);
    d_write = 1'b1; d_addr = 16'h0100; d_wdata = {4{32'h01234567}};
    exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h0100, wdata: {4{32'h01234567}}}); last_d = 1'b1;
    @(negedge clk);
    d_addr = 16'h0200; d_wdata = {4{32'h89ABCDEF}};
    complete({4{32'h55556666}}, 3);
    d_write = 1'b0;

    // 5: asynchronous reset mid SERVE_I abandons the transaction
    @(negedge clk);
    i_read = 1'b1; i_addr = 16'h0700;
    @(negedge clk);
    chk("t5_strobe", pmem_read, 1);
    #2 reset = 1'b0;
    #1 pmem_resp = 1'b1; pmem_rdata = {4{32'h77778888}};
    #1;
    chk("t5_read_drop", pmem_read, 0);
    chk("t5_no_resp", i_resp | d_resp, 0);
    chk("t5_addr_clr", pmem_address, 0);
    i_read = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b0;
    reset = 1'b1; last_d = 1'b0;
    @(negedge clk);
    chk("t5_idle", pmem_read | pmem_write, 0);
    i_read = 1'b1; i_addr = 16'h0300;
    exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h0300, wdata: '0});
    @(negedge clk);
    complete({4{32'h9999AAAA}}, 2);
    i_read = 1'b0;

    // 6: d_read and d_write together are serviced as a write
    @(negedge clk);
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0400; d_wdata = {4{32'hCAFEF00D}};
    exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h0400, wdata: {4{32'hCAFEF00D}}}); last_d = 1'b1;
    @(negedge clk);
    complete({4{32'hBBBBCCCC}}, 2);
    d_read = 1'b0; d_write = 1'b0;

    // pmem_resp while IDLE is ignored
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("idle_resp_ignored", i_resp | d_resp, 0);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("idle_no_strobe", pmem_read | pmem_write, 0);
    chk("sb_drained", LINE_W'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
